// File: rtl/regs_pkg.sv
// Shared constants, dump FSM encoding and small helpers for the register-file
// port controller.
package regs_pkg;

  localparam int NREGS = 16;
  localparam int AW    = 5;
  localparam int DW    = 32;

  // Dump sequencer state encoding.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DRAIN = 3'd1;
  localparam logic [2:0] ST_SEL   = 3'd2;
  localparam logic [2:0] ST_CAP   = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_DRAIN = ST_DRAIN,
    S_SEL   = ST_SEL,
    S_CAP   = ST_CAP,
    S_FIN   = ST_FIN
  } dump_state_e;

  // True when a register number addresses an architectural register.
  function automatic logic wnum_in_range(input logic [AW-1:0] num);
    return (num < AW'(NREGS));
  endfunction

endpackage

// File: rtl/regs_port_ctrl_if.sv
// Bundle of writeback requests, register-file port and dump stream signals.
// 'master' is the surrounding datapath/register file, 'slave' is the controller.
interface regs_port_ctrl_if;
  import regs_pkg::*;

  logic          wb0_valid;
  logic [AW-1:0] wb0_num;
  logic [DW-1:0] wb0_data;
  logic          wb0_ready;

  logic          wb1_valid;
  logic [AW-1:0] wb1_num;
  logic [DW-1:0] wb1_data;
  logic          wb1_ready;

  logic          rf_we;
  logic [AW-1:0] rf_wnum;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] rf_rnum_C;
  logic [DW-1:0] rf_rdata_C;

  logic          dump_start;
  logic          dump_valid;
  logic [AW-1:0] dump_idx;
  logic [DW-1:0] dump_data;
  logic          dump_done;
  logic          busy;
  logic          bad_wnum;

  modport master (
    output wb0_valid, wb0_num, wb0_data,
    input  wb0_ready,
    output wb1_valid, wb1_num, wb1_data,
    input  wb1_ready,
    input  rf_we, rf_wnum, rf_wdata, rf_rnum_C,
    output rf_rdata_C,
    output dump_start,
    input  dump_valid, dump_idx, dump_data, dump_done, busy, bad_wnum
  );

  modport slave (
    input  wb0_valid, wb0_num, wb0_data,
    output wb0_ready,
    input  wb1_valid, wb1_num, wb1_data,
    output wb1_ready,
    output rf_we, rf_wnum, rf_wdata, rf_rnum_C,
    input  rf_rdata_C,
    input  dump_start,
    output dump_valid, dump_idx, dump_data, dump_done, busy, bad_wnum
  );

endinterface

// File: rtl/regs_port_ctrl_rr_arb2.sv
// Two-input round-robin arbiter. A lone requester always wins; when both
// request, the pointer picks the winner and then flips to the other port.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic ptr_q;
  logic ptr_d;

  // Grant selection and pointer advance (only on a contested grant).
  always_comb begin
    grant = 2'b00;
    ptr_d = ptr_q;
    if (en) begin
      case (req)
        2'b01: grant = 2'b01;
        2'b10: grant = 2'b10;
        2'b11: begin
          if (ptr_q) begin
            grant = 2'b10;
          end else begin
            grant = 2'b01;
          end
          ptr_d = ~ptr_q;
        end
        default: grant = 2'b00;
      endcase
    end else begin
      grant = 2'b00;
    end
  end

  // Round-robin pointer register; port 0 is preferred after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regs_port_ctrl.sv
// Register-file port controller: arbitrates the single write port between the
// ALU and load writeback paths, and sequences a debug dump over read port C
// while holding off writes so the dump is a consistent snapshot.
module regs_port_ctrl
  import regs_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  regs_port_ctrl_if.slave  bus
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);

  dump_state_e   state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_wnum_q, rf_wnum_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;
  logic [AW-1:0] rf_rnum_c_q, rf_rnum_c_d;
  logic          dump_valid_q, dump_valid_d;
  logic [AW-1:0] dump_idx_q, dump_idx_d;
  logic [DW-1:0] dump_data_q, dump_data_d;
  logic          dump_done_q, dump_done_d;
  logic          busy_q, busy_d;
  logic          bad_wnum_q, bad_wnum_d;

  logic          arb_en;
  logic [1:0]    req;
  logic [1:0]    grant;
  logic          granted;
  logic [AW-1:0] sel_num;
  logic [DW-1:0] sel_data;

  // Grants only while idle and not in the cycle a dump is being started.
  assign arb_en = (state_q == S_IDLE) && !bus.dump_start;
  assign req    = {bus.wb1_valid, bus.wb0_valid};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en),
    .req   (req),
    .grant (grant)
  );

  assign bus.wb0_ready = grant[0];
  assign bus.wb1_ready = grant[1];

  // Route the granted requester's register number and data.
  always_comb begin
    granted  = |grant;
    sel_num  = bus.wb0_num;
    sel_data = bus.wb0_data;
    if (grant[1]) begin
      sel_num  = bus.wb1_num;
      sel_data = bus.wb1_data;
    end else begin
      sel_num  = bus.wb0_num;
      sel_data = bus.wb0_data;
    end
  end

  // Write issue: r0 writes are swallowed, out-of-range numbers raise a sticky flag.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_wnum_d  = rf_wnum_q;
    rf_wdata_d = rf_wdata_q;
    bad_wnum_d = bad_wnum_q;
    if (granted) begin
      if (!wnum_in_range(sel_num)) begin
        bad_wnum_d = 1'b1;
      end else if (sel_num != {AW{1'b0}}) begin
        rf_we_d    = 1'b1;
        rf_wnum_d  = sel_num;
        rf_wdata_d = sel_data;
      end else begin
        rf_we_d = 1'b0;
      end
    end else begin
      rf_we_d = 1'b0;
    end
  end

  // Dump sequencer: drain pending write, then select/capture each register.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rf_rnum_c_d  = rf_rnum_c_q;
    dump_valid_d = 1'b0;
    dump_done_d  = 1'b0;
    dump_idx_d   = dump_idx_q;
    dump_data_d  = dump_data_q;
    busy_d       = busy_q;
    case (state_q)
      S_IDLE: begin
        if (bus.dump_start) begin
          busy_d  = 1'b1;
          idx_d   = {AW{1'b0}};
          state_d = S_DRAIN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        rf_rnum_c_d = idx_q;
        state_d     = S_SEL;
      end
      S_SEL: begin
        state_d = S_CAP;
      end
      S_CAP: begin
        dump_data_d  = bus.rf_rdata_C;
        dump_idx_d   = idx_q;
        dump_valid_d = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = S_FIN;
        end else begin
          idx_d       = idx_q + IDX_ONE;
          rf_rnum_c_d = idx_q + IDX_ONE;
          state_d     = S_SEL;
        end
      end
      S_FIN: begin
        dump_done_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any dump in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      idx_q        <= {AW{1'b0}};
      rf_we_q      <= 1'b0;
      rf_wnum_q    <= {AW{1'b0}};
      rf_wdata_q   <= {DW{1'b0}};
      rf_rnum_c_q  <= {AW{1'b0}};
      dump_valid_q <= 1'b0;
      dump_idx_q   <= {AW{1'b0}};
      dump_data_q  <= {DW{1'b0}};
      dump_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      bad_wnum_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rf_we_q      <= rf_we_d;
      rf_wnum_q    <= rf_wnum_d;
      rf_wdata_q   <= rf_wdata_d;
      rf_rnum_c_q  <= rf_rnum_c_d;
      dump_valid_q <= dump_valid_d;
      dump_idx_q   <= dump_idx_d;
      dump_data_q  <= dump_data_d;
      dump_done_q  <= dump_done_d;
      busy_q       <= busy_d;
      bad_wnum_q   <= bad_wnum_d;
    end
  end

  assign bus.rf_we      = rf_we_q;
  assign bus.rf_wnum    = rf_wnum_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.rf_rnum_C  = rf_rnum_c_q;
  assign bus.dump_valid = dump_valid_q;
  assign bus.dump_idx   = dump_idx_q;
  assign bus.dump_data  = dump_data_q;
  assign bus.dump_done  = dump_done_q;
  assign bus.busy       = busy_q;
  assign bus.bad_wnum   = bad_wnum_q;

endmodule

// File: doc/regs_port_ctrl.md
Name: regs_port_ctrl

Overview:
- Controller in front of the 16x32 multi-cycle CPU register file.
- Shares the single write port between two writeback requesters, ALU (port 0) and load (port 1), using round-robin arbitration with valid/ready handshakes.
- Sequences a debug dump that walks read port C over r0..r15 and streams out a consistent snapshot.
- Sits between the control unit/datapath and the register file; drives the file's we/wnum/wdata and rnum_C.

Parameters:
- NREGS, 16, number of architectural registers walked by the dump.
- AW, 5, register-number width.
- DW, 32, data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; one clock, asynchronous, active-low.
- wb0_valid  input  1  ALU writeback request.
- wb0_num  input  AW  ALU destination register.
- wb0_data  input  DW  ALU result.
- wb0_ready  output  1  ALU request accepted this cycle.
- wb1_valid  input  1  load writeback request.
- wb1_num  input  AW  load destination register.
- wb1_data  input  DW  load data.
- wb1_ready  output  1  load request accepted this cycle.
- rf_we  output  1  register-file write enable (registered).
- rf_wnum  output  AW  register-file write number (registered).
- rf_wdata  output  DW  register-file write data (registered).
- rf_rnum_C  output  AW  register-file read port C select (registered).
- rf_rdata_C  input  DW  register-file read port C data.
- dump_start  input  1  one-cycle pulse that starts a snapshot.
- dump_valid  output  1  dump_data/dump_idx valid (one-cycle pulse).
- dump_idx  output  AW  index of the dumped register.
- dump_data  output  DW  dumped register value.
- dump_done  output  1  one-cycle pulse after the last register.
- busy  output  1  dump in progress; writes are blocked.
- bad_wnum  output  1  sticky flag: a request targeted wnum >= NREGS.

Behaviour:
Reset (rst=0, asynchronous):
- All registered outputs are 0: rf_we, rf_wnum, rf_wdata, rf_rnum_C, dump_valid, dump_idx, dump_data, dump_done, busy, bad_wnum.
- Round-robin pointer resets to port 0.
- FSM goes to IDLE.
- Reset mid-dump abandons the dump; dump_done is not issued.

Arbitration (only in IDLE, and only when dump_start=0 this cycle):
- wbX_ready is combinational and high for at most one port per cycle.
- A transfer occurs when wbX_valid and wbX_ready are both high.
- With one requester valid, that requester is granted.
- With both valid, the port pointed to by the round-robin pointer is granted; the pointer then moves to the other port.
- The pointer changes only on a grant with both ports valid.

Write issue:
- A granted request with 1 <= num < NREGS produces rf_we=1 with rf_wnum/rf_wdata on the next cycle, for exactly one cycle. Latency is one cycle; throughput is one write per cycle.
- num==0 is acknowledged with no write (rf_we stays 0).
- num >= NREGS is acknowledged with no write and sets bad_wnum, which stays set until reset.
- Requesters must hold valid, num and data stable until ready; the block does not check this.

Dump FSM:
- IDLE: on dump_start, busy<=1, idx<=0, go to DRAIN. No grants are issued in the dump_start cycle.
- DRAIN: one cycle, so that any rf_we issued last cycle lands. rf_rnum_C<=idx. Go to SEL.
- SEL: one cycle of settling for rf_rdata_C. Go to CAP.
- CAP: dump_data<=rf_rdata_C, dump_idx<=idx, dump_valid<=1.
  - If idx==NREGS-1: go to FIN.
  - Otherwise: idx<=idx+1, rf_rnum_C<=idx+1, go to SEL.
- FIN: dump_done<=1, busy<=0, go to IDLE.
- Throughout DRAIN/SEL/CAP/FIN: wb0_ready=wb1_ready=0 and rf_we=0, so pending requests stall and are not dropped.
- dump_start while busy is ignored.
- A dump takes 1 + 2*NREGS + 1 = 34 cycles from dump_start to dump_done.
- dump_valid and dump_done pulse for one cycle each; all other dump outputs hold their last value.

Decomposition:
- Shared package regs_pkg:
  - constants NREGS=16, AW=5, DW=32;
  - dump FSM state encoding (IDLE, DRAIN, SEL, CAP, FIN) as 3-bit localparams.
- One sub-module is natural: rr_arb2, a 2-input round-robin arbiter (req[1:0], grant[1:0], update enable, pointer flop).
- Write-issue and dump FSM logic stay in the top module.

Test Plan:
- Reset then wb0 write r3=0xDEADBEEF -> wb0_ready=1 in the same cycle; next cycle rf_we=1, rf_wnum=3, rf_wdata=0xDEADBEEF; the cycle after, rf_we=0.
- wb0 and wb1 both held valid for 4 cycles after reset -> grants in order 0,1,0,1; rf_we high for 4 consecutive cycles.
- wb1 request to r0 with data 0x1234 -> wb1_ready=1 and rf_we stays 0; request to num=17 -> acknowledged, no write, bad_wnum=1 and stays 1.
- Preload r1..r15 with value=index*0x11, then dump_start -> 16 dump_valid pulses, idx 0..15 with data 0, 0x11 .. 0xFF; dump_done 34 cycles after dump_start; busy low afterwards.
- wb0 write r5=0xAA in the cycle before dump_start, with wb1 valid (r6=0xBB) during the dump -> dump shows r5=0xAA; wb1_ready stays 0 until after dump_done; r6 is written only after the dump.
- rst driven low during the 10th dump cycle -> all outputs are 0 immediately; no dump_done; after release a new dump_start completes normally.
